// File: rtl/rgb_pkg.sv
// Shared phase encoding and default sizing for the RGB colour-fade sequencer.
package rgb_pkg;

   localparam int unsigned DUTY_W           = 7;
   localparam int unsigned MAX_DUTY_DEFAULT = 50;

   // Encoding 2'd3 is deliberately left unnamed: it is the illegal phase.
   typedef enum logic [1:0] {
      PH_RG = 2'd0,
      PH_GB = 2'd1,
      PH_BR = 2'd2
   } phase_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running step prescaler: one-cycle tick every DIV enabled clocks, cleared while disabled.
module tick_prescaler #(
   parameter int unsigned DIV = 5000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam logic [27:0] TERMINAL = 28'(DIV - 1);

   logic [27:0] count;

   assign tick = en && (count == TERMINAL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (!en || tick) begin
         count <= '0;
      end else begin
         count <= count + 28'd1;
      end
   end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Cross-fades a constant total duty around R->G->B->R, stepping only on PWM frame boundaries.
module rgb_fade_sequencer #(
   parameter int unsigned MAX_DUTY = rgb_pkg::MAX_DUTY_DEFAULT,
   parameter int unsigned DUTY_W   = rgb_pkg::DUTY_W,
   parameter int unsigned STEP_DIV = 5000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              frame_end,
   output logic [DUTY_W-1:0] duty_r,
   output logic [DUTY_W-1:0] duty_g,
   output logic [DUTY_W-1:0] duty_b,
   output logic              duty_valid,
   output logic [1:0]        phase
);

   import rgb_pkg::*;

   localparam logic [DUTY_W-1:0] FULL = DUTY_W'(MAX_DUTY);
   localparam logic [DUTY_W-1:0] ONE  = DUTY_W'(1);

   phase_t            phase_q, phase_nx;
   logic [DUTY_W-1:0] r_q, g_q, b_q;
   logic [DUTY_W-1:0] r_nx, g_nx, b_nx;
   logic              pending_q, pending_nx;
   logic              valid_q;
   logic              tick;
   logic              step;

   tick_prescaler #(.DIV(STEP_DIV)) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q   <= PH_RG;
         r_q       <= FULL;
         g_q       <= '0;
         b_q       <= '0;
         pending_q <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         phase_q   <= phase_nx;
         r_q       <= r_nx;
         g_q       <= g_nx;
         b_q       <= b_nx;
         pending_q <= pending_nx;
         valid_q   <= step;
      end
   end

   always_comb begin
      step       = en && frame_end && (pending_q || tick);
      pending_nx = pending_q;
      phase_nx   = phase_q;
      r_nx       = r_q;
      g_nx       = g_q;
      b_nx       = b_q;

      if (!en || step) begin
         pending_nx = 1'b0;
      end else if (tick) begin
         pending_nx = 1'b1;
      end

      // A zero source channel only happens with MAX_DUTY=0; the step then leaves everything put.
      if (step) begin
         case (phase_q)
            PH_RG: if (r_q != '0) begin
               r_nx = r_q - ONE;
               g_nx = g_q + ONE;
               if (r_q == ONE) phase_nx = PH_GB;
            end
            PH_GB: if (g_q != '0) begin
               g_nx = g_q - ONE;
               b_nx = b_q + ONE;
               if (g_q == ONE) phase_nx = PH_BR;
            end
            PH_BR: if (b_q != '0) begin
               b_nx = b_q - ONE;
               r_nx = r_q + ONE;
               if (b_q == ONE) phase_nx = PH_RG;
            end
            default: begin
               phase_nx = PH_RG;
               r_nx     = FULL;
               g_nx     = '0;
               b_nx     = '0;
            end
         endcase
      end
   end

   assign duty_r     = r_q;
   assign duty_g     = g_q;
   assign duty_b     = b_q;
   assign duty_valid = valid_q;
   assign phase      = phase_q;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Scoreboard bench for rgb_fade_sequencer: three instances (MAX_DUTY 50, 3 and 0).
module tb_rgb_fade_sequencer;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic en_a  = 1'b0;
   logic fe_a  = 1'b0;
   logic en_b  = 1'b0;
   logic fe_b  = 1'b0;

   logic [6:0] dr[3];
   logic [6:0] dg[3];
   logic [6:0] db[3];
   logic [1:0] ph[3];
   logic       dv[3];
   logic       en_v[3];
   logic       fe_v[3];

   int checks = 0;
   int errors = 0;

   typedef struct {
      int     r;
      int     g;
      int     b;
      int     ph;
      longint cyc;
   } exp_t;

   exp_t   q0[$];
   exp_t   q1[$];
   exp_t   q2[$];
   int     ms[3]   = '{50, 3, 0};
   int     divs[3] = '{4, 1, 1};
   int     m_cnt[3];
   bit     m_pend[3];
   int     m_n[3];
   bit     m_tick, m_step;
   longint cycle_no  = 0;
   int     rst_count = 0;
   int     last_rst  = 0;
   int     vcnt[3]   = '{0, 0, 0};
   logic [6:0] pr[3], pg[3], pb[3];
   exp_t   e_mon;

   rgb_fade_sequencer #(.MAX_DUTY(50), .DUTY_W(7), .STEP_DIV(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en_a), .frame_end(fe_a),
      .duty_r(dr[0]), .duty_g(dg[0]), .duty_b(db[0]), .duty_valid(dv[0]), .phase(ph[0]));

   rgb_fade_sequencer #(.MAX_DUTY(3), .DUTY_W(7), .STEP_DIV(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en_b), .frame_end(fe_b),
      .duty_r(dr[1]), .duty_g(dg[1]), .duty_b(db[1]), .duty_valid(dv[1]), .phase(ph[1]));

   rgb_fade_sequencer #(.MAX_DUTY(0), .DUTY_W(7), .STEP_DIV(1)) dut_c (
      .clk(clk), .rst_n(rst_n), .en(en_b), .frame_end(fe_b),
      .duty_r(dr[2]), .duty_g(dg[2]), .duty_b(db[2]), .duty_valid(dv[2]), .phase(ph[2]));

   assign en_v[0] = en_a;
   assign en_v[1] = en_b;
   assign en_v[2] = en_b;
   assign fe_v[0] = fe_a;
   assign fe_v[1] = fe_b;
   assign fe_v[2] = fe_b;

   always #5 clk = ~clk;

   // Closed-form duties after n applied steps (n taken modulo 3*m).
   function automatic exp_t expect_after(int m, int n);
      exp_t e;
      e.cyc = 0;
      if (m == 0 || n == 0) begin
         e.r = m; e.g = 0; e.b = 0; e.ph = 0;
      end else if (n <= m) begin
         e.r = m - n; e.g = n; e.b = 0; e.ph = (n == m) ? 1 : 0;
      end else if (n <= 2 * m) begin
         e.r = 0; e.g = 2 * m - n; e.b = n - m; e.ph = (n == 2 * m) ? 2 : 1;
      end else begin
         e.r = n - 2 * m; e.g = 0; e.b = 3 * m - n; e.ph = 2;
      end
      return e;
   endfunction

   function automatic void q_push(int i, exp_t e);
      case (i)
         0: q0.push_back(e);
         1: q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endfunction

   function automatic int q_size(int i);
      case (i)
         0: return q0.size();
         1: return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic exp_t q_pop(int i);
      case (i)
         0: return q0.pop_front();
         1: return q1.pop_front();
         default: return q2.pop_front();
      endcase
   endfunction

   function automatic exp_t q_front(int i);
      case (i)
         0: return q0[0];
         1: return q1[0];
         default: return q2[0];
      endcase
   endfunction

   // Reference model: prescaler/pending behaviour, pushes the expected post-step state.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_pend[i] = 1'b0; m_n[i] = 0;
         end
         q0.delete(); q1.delete(); q2.delete();
         rst_count++;
      end else begin
         cycle_no++;
         for (int i = 0; i < 3; i++) begin
            m_tick = en_v[i] && (m_cnt[i] == divs[i] - 1);
            m_step = en_v[i] && fe_v[i] && (m_pend[i] || m_tick);
            if (!en_v[i]) begin
               m_cnt[i] = 0; m_pend[i] = 1'b0;
            end else begin
               m_cnt[i] = m_tick ? 0 : m_cnt[i] + 1;
               if (m_step) m_pend[i] = 1'b0;
               else if (m_tick) m_pend[i] = 1'b1;
            end
            if (m_step) begin
               exp_t e;
               m_n[i] = (ms[i] == 0) ? 0 : (m_n[i] + 1) % (3 * ms[i]);
               e = expect_after(ms[i], m_n[i]);
               e.cyc = cycle_no;
               q_push(i, e);
            end
         end
      end
   end

   // Monitor: invariant, scoreboard pop on duty_valid, duties held between steps.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (int'(dr[i]) + int'(dg[i]) + int'(db[i]) != ms[i]) begin
            errors++;
            $display("FAIL invariant dut%0d: sum %0d, required %0d", i,
                     int'(dr[i]) + int'(dg[i]) + int'(db[i]), ms[i]);
         end
         if (q_size(i) > 0) begin
            e_mon = q_front(i);
            if (e_mon.cyc < cycle_no) begin
               checks++; errors++;
               $display("FAIL missed_valid dut%0d: no duty_valid, required at cycle %0d", i, e_mon.cyc);
               e_mon = q_pop(i);
            end
         end
         if (dv[i] === 1'b1) begin
            vcnt[i]++;
            checks++;
            if (q_size(i) == 0) begin
               errors++;
               $display("FAIL unexpected_valid dut%0d: duty_valid=1 at cycle %0d, required 0", i, cycle_no);
            end else begin
               e_mon = q_pop(i);
               if (e_mon.cyc != cycle_no || dr[i] !== 7'(e_mon.r) || dg[i] !== 7'(e_mon.g) ||
                   db[i] !== 7'(e_mon.b) || ph[i] !== 2'(e_mon.ph)) begin
                  errors++;
                  $display("FAIL scoreboard dut%0d: got %0d/%0d/%0d ph%0d cyc%0d, required %0d/%0d/%0d ph%0d cyc%0d",
                           i, dr[i], dg[i], db[i], ph[i], cycle_no,
                           e_mon.r, e_mon.g, e_mon.b, e_mon.ph, e_mon.cyc);
               end
            end
         end else begin
            checks++;
            if (rst_count == last_rst && (dr[i] !== pr[i] || dg[i] !== pg[i] || db[i] !== pb[i])) begin
               errors++;
               $display("FAIL hold dut%0d: duties %0d/%0d/%0d changed from %0d/%0d/%0d without duty_valid",
                        i, dr[i], dg[i], db[i], pr[i], pg[i], pb[i]);
            end
         end
         pr[i] = dr[i]; pg[i] = dg[i]; pb[i] = db[i];
      end
      last_rst = rst_count;
   end

   task automatic tk(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en_a = 1'b0; fe_a = 1'b0; en_b = 1'b0; fe_b = 1'b0;
      tk(1);
      checks++;
      if ({dr[0], dg[0], db[0], ph[0], dv[0]} !== {7'd50, 7'd0, 7'd0, 2'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_a: got %0d/%0d/%0d ph%0d v%0d, required 50/0/0 ph0 v0", dr[0], dg[0], db[0], ph[0], dv[0]);
      end
      checks++;
      if ({dr[1], dg[1], db[1], ph[1], dv[1]} !== {7'd3, 7'd0, 7'd0, 2'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_b: got %0d/%0d/%0d ph%0d v%0d, required 3/0/0 ph0 v0", dr[1], dg[1], db[1], ph[1], dv[1]);
      end
      tk(1);
      rst_n = 1'b1;
   endtask

   task automatic test_boundary_gating();
      int v0;
      v0 = vcnt[0];
      en_a = 1'b1;
      tk(9);  fe_a = 1'b1;
      tk(1);  fe_a = 1'b0;
      @(negedge clk);
      checks++;
      if ({dv[0], dr[0], dg[0], db[0]} !== {1'b1, 7'd49, 7'd1, 7'd0}) begin
         errors++;
         $display("FAIL gate_step1: got v%0d %0d/%0d/%0d, required v1 49/1/0", dv[0], dr[0], dg[0], db[0]);
      end
      tk(9);  fe_a = 1'b1;
      tk(1);  fe_a = 1'b0;
      @(negedge clk);
      checks++;
      if ({dv[0], dr[0], dg[0], db[0]} !== {1'b1, 7'd48, 7'd2, 7'd0}) begin
         errors++;
         $display("FAIL gate_step2: got v%0d %0d/%0d/%0d, required v1 48/2/0", dv[0], dr[0], dg[0], db[0]);
      end
      tk(2);
      checks++;
      if (vcnt[0] - v0 != 2) begin
         errors++;
         $display("FAIL gate_pulses: got %0d duty_valid pulses, required 2", vcnt[0] - v0);
      end
   endtask

   task automatic test_phase_wrap();
      int tr[9] = '{2, 1, 0, 0, 0, 0, 1, 2, 3};
      int tg[9] = '{1, 2, 3, 2, 1, 0, 0, 0, 0};
      int tb[9] = '{0, 0, 0, 1, 2, 3, 2, 1, 0};
      int tp[9] = '{0, 0, 1, 1, 1, 2, 2, 2, 0};
      @(negedge clk);
      en_b = 1'b1; fe_b = 1'b1;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         checks++;
         if ({dv[1], dr[1], dg[1], db[1], ph[1]} !== {1'b1, 7'(tr[k]), 7'(tg[k]), 7'(tb[k]), 2'(tp[k])}) begin
            errors++;
            $display("FAIL wrap_step%0d: got v%0d %0d/%0d/%0d ph%0d, required v1 %0d/%0d/%0d ph%0d",
                     k + 1, dv[1], dr[1], dg[1], db[1], ph[1], tr[k], tg[k], tb[k], tp[k]);
         end
         checks++;
         if ({dv[2], dr[2], dg[2], db[2], ph[2]} !== {1'b1, 7'd0, 7'd0, 7'd0, 2'd0}) begin
            errors++;
            $display("FAIL zero_duty_step%0d: got v%0d %0d/%0d/%0d ph%0d, required v1 0/0/0 ph0",
                     k + 1, dv[2], dr[2], dg[2], db[2], ph[2]);
         end
      end
      fe_b = 1'b0;
   endtask

   task automatic test_coincident();
      int v0;
      tk(1);  rst_n = 1'b0; en_a = 1'b1; fe_a = 1'b0;
      tk(1);  rst_n = 1'b1;
      tk(2);  fe_a = 1'b1;
      tk(1);
      checks++;
      if (dv[0] !== 1'b0) begin
         errors++;
         $display("FAIL early_tick: got duty_valid %0d before STEP_DIV cycles, required 0", dv[0]);
      end
      tk(1);  fe_a = 1'b0;
      checks++;
      if ({dv[0], dr[0], dg[0], db[0]} !== {1'b1, 7'd49, 7'd1, 7'd0}) begin
         errors++;
         $display("FAIL coincident: got v%0d %0d/%0d/%0d, required v1 49/1/0", dv[0], dr[0], dg[0], db[0]);
      end
      tk(9);  v0 = vcnt[0]; fe_a = 1'b1;
      tk(2);  fe_a = 1'b0;
      tk(3);
      checks++;
      if (vcnt[0] - v0 != 1 || {dr[0], dg[0], db[0]} !== {7'd48, 7'd2, 7'd0}) begin
         errors++;
         $display("FAIL two_ticks: got %0d steps, %0d/%0d/%0d, required 1 step, 48/2/0",
                  vcnt[0] - v0, dr[0], dg[0], db[0]);
      end
   endtask

   task automatic test_enable_gate();
      int v0;
      v0 = vcnt[0];
      en_a = 1'b0;
      for (int j = 0; j < 20; j++) begin
         fe_a = (j % 3 == 0);
         tk(1);
      end
      fe_a = 1'b0;
      tk(1);
      checks++;
      if (vcnt[0] - v0 != 0 || {dr[0], dg[0], db[0]} !== {7'd48, 7'd2, 7'd0}) begin
         errors++;
         $display("FAIL disabled: got %0d steps, %0d/%0d/%0d, required 0 steps, 48/2/0",
                  vcnt[0] - v0, dr[0], dg[0], db[0]);
      end
      en_a = 1'b1; fe_a = 1'b1; v0 = vcnt[0];
      tk(3);
      checks++;
      if (dv[0] !== 1'b0 || vcnt[0] - v0 != 0) begin
         errors++;
         $display("FAIL reenable_early: got v%0d after %0d steps, required v0 after 0 steps", dv[0], vcnt[0] - v0);
      end
      tk(1);  fe_a = 1'b0;
      checks++;
      if ({dv[0], dr[0], dg[0], db[0]} !== {1'b1, 7'd47, 7'd3, 7'd0}) begin
         errors++;
         $display("FAIL reenable_step: got v%0d %0d/%0d/%0d, required v1 47/3/0", dv[0], dr[0], dg[0], db[0]);
      end
   endtask

   task automatic test_async_reset_gb();
      @(negedge clk);
      fe_b = 1'b1;
      repeat (4) @(negedge clk);
      fe_b = 1'b0;
      checks++;
      if ({dr[1], dg[1], db[1], ph[1]} !== {7'd0, 7'd2, 7'd1, 2'd1}) begin
         errors++;
         $display("FAIL reach_gb: got %0d/%0d/%0d ph%0d, required 0/2/1 ph1", dr[1], dg[1], db[1], ph[1]);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({dr[1], dg[1], db[1], ph[1], dv[1]} !== {7'd3, 7'd0, 7'd0, 2'd0, 1'b0}) begin
         errors++;
         $display("FAIL async_reset_b: got %0d/%0d/%0d ph%0d v%0d, required 3/0/0 ph0 v0", dr[1], dg[1], db[1], ph[1], dv[1]);
      end
      checks++;
      if ({dr[0], dg[0], db[0], ph[0], dv[0]} !== {7'd50, 7'd0, 7'd0, 2'd0, 1'b0}) begin
         errors++;
         $display("FAIL async_reset_a: got %0d/%0d/%0d ph%0d v%0d, required 50/0/0 ph0 v0", dr[0], dg[0], db[0], ph[0], dv[0]);
      end
      tk(1);
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      int v0;
      v0 = vcnt[0];
      for (int j = 0; j < 10000; j++) begin
         tk(1);
         fe_a = ($urandom_range(0, 7) == 0);
         en_a = ($urandom_range(0, 15) != 0);
         fe_b = ($urandom_range(0, 1) == 1);
         en_b = ($urandom_range(0, 9) != 0);
      end
      fe_a = 1'b0; fe_b = 1'b0;
      tk(3);
      checks++;
      if (q0.size() + q1.size() + q2.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d outstanding steps, required 0", q0.size() + q1.size() + q2.size());
      end
      checks++;
      if (vcnt[0] - v0 < 200) begin
         errors++;
         $display("FAIL random_activity: got %0d steps on dut0, required at least 200", vcnt[0] - v0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation still running at %0t", $time);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_boundary_gating();
      test_phase_wrap();
      test_coincident();
      test_enable_gate();
      test_async_reset_gb();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rgb_fade_sequencer.md
RGB_FADE_SEQUENCER -- requirements
Module: rgb_fade_sequencer

Interface
REQ-001 Parameter MAX_DUTY, default 50: full-scale duty value; the sum of the three channel duties.
REQ-002 Parameter DUTY_W, default 7: duty output width; MAX_DUTY SHALL be at most 2^DUTY_W-1.
REQ-003 Parameter STEP_DIV, default 5000000: clk cycles per fade step; legal range 1..2^28-1.
REQ-004 clk  in  1  single system clock; all state on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 en  in  1  fade enable; when low the prescaler is cleared and the duties freeze.
REQ-007 frame_end  in  1  one-cycle pulse from the downstream PWM stage marking the PWM period boundary.
REQ-008 duty_r / duty_g / duty_b  out  DUTY_W each  registered duty commands to the red, green and blue PWM channels.
REQ-009 duty_valid  out  1  one-cycle pulse, high in the cycle the new duties first appear.
REQ-010 phase  out  2  current fade phase: 0 = RG, 1 = GB, 2 = BR.

Function
REQ-011 Prescaler: 28-bit counter 0..STEP_DIV-1 while en=1; at terminal count it wraps to 0 and asserts tick for one cycle.
REQ-012 step_pending SHALL set on tick and clear when a step is applied; a tick while already pending is absorbed, so steps are never queued beyond one.
REQ-013 A step SHALL be applied at the clk edge where frame_end=1, en=1 and (step_pending=1 or tick=1); a tick and frame_end in the same cycle apply that step immediately.
REQ-014 Duties SHALL change only at a step edge, so the PWM never sees a mid-period update.
REQ-015 Phase RG step: duty_r -1, duty_g +1; after the step, if duty_r=0 then phase becomes GB.
REQ-016 Phase GB step: duty_g -1, duty_b +1; after the step, if duty_g=0 then phase becomes BR.
REQ-017 Phase BR step: duty_b -1, duty_r +1; after the step, if duty_b=0 then phase becomes RG.
REQ-018 Invariant: duty_r+duty_g+duty_b = MAX_DUTY at every cycle, and no channel underflows or exceeds MAX_DUTY.
REQ-019 Encoding 3 on phase is illegal; if entered, the next step edge SHALL force the reset state.
REQ-020 duty_valid SHALL be high exactly in the cycle after each step edge, and at no other time.
REQ-021 Full-cycle period: 3*MAX_DUTY applied steps return the block to the reset duties and phase RG.
REQ-022 en falling SHALL clear the prescaler and step_pending within one edge; duties and phase hold; a frame_end while en=0 has no effect.
REQ-023 With MAX_DUTY=0, duties SHALL stay 0, phase SHALL stay RG, and duty_valid SHALL still pulse on each step.

Reset
REQ-024 rst_n low SHALL immediately force duty_r=MAX_DUTY, duty_g=0, duty_b=0, phase=RG, duty_valid=0, prescaler=0 and step_pending=0.
REQ-025 Reset asserted mid-fade SHALL discard any pending step; after release the first tick occurs STEP_DIV cycles later.
REQ-026 Reset deassertion is synchronised externally; the block needs no internal synchroniser.

Structure
REQ-027 A shared package rgb_pkg SHALL hold the phase encoding constants (PH_RG, PH_GB, PH_BR), DUTY_W and the MAX_DUTY default.
REQ-028 The prescaler SHALL be one sub-module, tick_prescaler (parameter DIV, ports clk, rst_n, en, tick).
REQ-029 The sequencer FSM and duty registers SHALL be in rgb_fade_sequencer; no other hierarchy.

Verification
REQ-030 Reset check (STEP_DIV=4, MAX_DUTY=50): hold rst_n low -> duties 50/0/0, phase 0, duty_valid 0.
REQ-031 Boundary gating: frame_end every 10 cycles with en=1 -> one step per frame_end after each tick; duties go 49/1/0 then 48/2/0; duty_valid pulses only then.
REQ-032 Phase wrap (MAX_DUTY=3): frame_end each cycle -> sequence 3/0/0, 2/1/0, 1/2/0, 0/3/0 (phase 1), ... back to 3/0/0 after 9 steps; sum is 3 throughout.
REQ-033 Coincident events: tick and frame_end in the same cycle -> step applied at that edge; two ticks before one frame_end -> only one step applied.
REQ-034 en low for 20 cycles with frame_end pulsing -> duties frozen, no duty_valid; after re-enable the first step follows STEP_DIV cycles plus the next frame_end.
REQ-035 Asynchronous reset mid-phase GB (duties 0/2/1) -> immediate 50/0/0 (phase 0) with no clk edge required; the invariant assertion holds over a 10k-cycle random frame_end run.
